beam_profile_stats: RTL and testbench



---
 rtl/beam_stats_pkg.sv | 22 ++
 rtl/profile_accumulator.sv | 60 ++++++
 rtl/beam_profile_stats.sv | 140 ++++++++++++++
 tb/tb_beam_profile_stats.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/beam_stats_pkg.sv
// Shared types and width helpers for the beam profile statistics block.
package beam_stats_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Widths chosen so a full frame of max-valued samples cannot overflow.
  function automatic int sum_w(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int wsum_w(input int data_w, input int addr_w);
    return data_w + 2 * addr_w;
  endfunction
endpackage

// File: rtl/profile_accumulator.sv
// Clip-and-accumulate datapath: pedestal clip stage, then sum/weighted-sum/peak.
module profile_accumulator
  import beam_stats_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int THRESHOLD = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic                                   sample_valid,
  input  logic [ADDR_W-1:0]                      sample_ch,
  input  logic [DATA_W-1:0]                      sample_data,
  output logic [sum_w(DATA_W, ADDR_W)-1:0]       sum,
  output logic [wsum_w(DATA_W, ADDR_W)-1:0]      wsum,
  output logic [DATA_W-1:0]                      peak_value,
  output logic [ADDR_W-1:0]                      peak_channel
);
  localparam int SUM_W  = sum_w(DATA_W, ADDR_W);
  localparam int WSUM_W = wsum_w(DATA_W, ADDR_W);
  localparam logic [DATA_W-1:0] TH = DATA_W'(THRESHOLD);

  logic                     clip_vld;
  logic [ADDR_W-1:0]        clip_ch;
  logic [DATA_W-1:0]        clip_data;
  logic [DATA_W+ADDR_W-1:0] prod;

  assign prod = {{ADDR_W{1'b0}}, clip_data} * {{DATA_W{1'b0}}, clip_ch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_vld     <= 1'b0;
      clip_ch      <= '0;
      clip_data    <= '0;
      sum          <= '0;
      wsum         <= '0;
      peak_value   <= '0;
      peak_channel <= '0;
    end else begin
      clip_vld  <= sample_valid;
      clip_ch   <= sample_ch;
      clip_data <= (sample_data > TH) ? sample_data - TH : '0;
      if (clear) begin
        sum          <= '0;
        wsum         <= '0;
        peak_value   <= '0;
        peak_channel <= '0;
      end else if (clip_vld) begin
        sum  <= sum + SUM_W'(clip_data);
        wsum <= wsum + WSUM_W'(prod);
        // Strict compare keeps the lowest channel on ties.
        if (clip_data > peak_value) begin
          peak_value   <= clip_data;
          peak_channel <= clip_ch;
        end
      end
    end
  end
endmodule

// File: rtl/beam_profile_stats.sv
// Post-frame scan of the calibrated RAM, reducing the beam profile to
// thresholded sum, channel-weighted sum and peak value/channel.
module beam_profile_stats
  import beam_stats_pkg::*;
#(
  parameter int N_CH        = 320,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BASE_ADDR   = 1,
  parameter int START_DELAY = 4,
  parameter int THRESHOLD   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [ADDR_W-1:0]              rd_address,
  output logic                           rd_enable,
  input  logic [DATA_W-1:0]              rd_data,
  output logic [DATA_W+ADDR_W-1:0]       sum_out,
  output logic [DATA_W+2*ADDR_W-1:0]     wsum_out,
  output logic [DATA_W-1:0]              peak_value,
  output logic [ADDR_W-1:0]              peak_channel,
  output logic                           result_valid,
  output logic                           busy,
  output logic                           overrun
);
  localparam int SUM_W  = sum_w(DATA_W, ADDR_W);
  localparam int WSUM_W = wsum_w(DATA_W, ADDR_W);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                clear;
  logic                vld_d1;
  logic [ADDR_W-1:0]   ch_d1;
  logic [SUM_W-1:0]    acc_sum;
  logic [WSUM_W-1:0]   acc_wsum;
  logic [DATA_W-1:0]   acc_peak;
  logic [ADDR_W-1:0]   acc_peak_ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter serves the start delay, the channel index and the drain.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clear     = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_WAIT;
        cnt_nxt   = ADDR_W'(START_DELAY - 1);
        clear     = 1'b1;
      end
      ST_WAIT: if (cnt == '0) begin
        state_nxt = ST_SCAN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
      ST_SCAN: if (cnt == ADDR_W'(N_CH - 1)) begin
        state_nxt = ST_DRAIN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      ST_DRAIN: if (cnt == ADDR_W'(1)) begin
        state_nxt = ST_DONE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_enable  = (state == ST_SCAN);
  assign rd_address = rd_enable ? ADDR_W'(BASE_ADDR) + cnt : '0;

  // Tag returning RAM data with the channel that addressed it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d1 <= 1'b0;
      ch_d1  <= '0;
    end else begin
      vld_d1 <= rd_enable;
      ch_d1  <= cnt;
    end
  end

  profile_accumulator #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .THRESHOLD(THRESHOLD)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .sample_valid(vld_d1),
    .sample_ch   (ch_d1),
    .sample_data (rd_data),
    .sum         (acc_sum),
    .wsum        (acc_wsum),
    .peak_value  (acc_peak),
    .peak_channel(acc_peak_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out      <= '0;
      wsum_out     <= '0;
      peak_value   <= '0;
      peak_channel <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= (state == ST_DONE);
      if (start && busy)
        overrun <= 1'b1;
      if (state == ST_IDLE && start)
        busy <= 1'b1;
      else if (state == ST_DONE)
        busy <= 1'b0;
      if (state == ST_DONE) begin
        sum_out      <= acc_sum;
        wsum_out     <= acc_wsum;
        peak_value   <= acc_peak;
        peak_channel <= acc_peak_ch;
      end
    end
  end
endmodule

// File: tb/tb_beam_profile_stats.sv
// Scoreboard bench: two instances (threshold 0 and 10) fed from RAM models.
module tb_beam_profile_stats;
  typedef struct packed {
    logic [40:0] sum;
    logic [49:0] wsum;
    logic [31:0] pv;
    logic [8:0]  pc;
  } exp_t;

  logic clk, rst, start_drv, sel;
  logic start0, start1;
  logic [8:0]  addr0, addr1, pc0, pc1;
  logic        en0, en1, rv0, rv1, busy0, busy1, ovr0, ovr1;
  logic [31:0] rdat0, rdat1, pv0, pv1;
  logic [40:0] sum0, sum1;
  logic [49:0] wsum0, wsum1;
  logic [31:0] mem0 [0:511];
  logic [31:0] mem1 [0:511];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  assign start0 = start_drv & ~sel;
  assign start1 = start_drv & sel;

  wire        v_en   = sel ? en1   : en0;
  wire [8:0]  v_addr = sel ? addr1 : addr0;
  wire        v_rv   = sel ? rv1   : rv0;
  wire        v_busy = sel ? busy1 : busy0;
  wire        v_ovr  = sel ? ovr1  : ovr0;
  wire [40:0] v_sum  = sel ? sum1  : sum0;
  wire [49:0] v_wsum = sel ? wsum1 : wsum0;
  wire [31:0] v_pv   = sel ? pv1   : pv0;
  wire [8:0]  v_pc   = sel ? pc1   : pc0;

  beam_profile_stats #(.THRESHOLD(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .rd_address(addr0), .rd_enable(en0),
    .rd_data(rdat0), .sum_out(sum0), .wsum_out(wsum0), .peak_value(pv0),
    .peak_channel(pc0), .result_valid(rv0), .busy(busy0), .overrun(ovr0));

  beam_profile_stats #(.THRESHOLD(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rd_address(addr1), .rd_enable(en1),
    .rd_data(rdat1), .sum_out(sum1), .wsum_out(wsum1), .peak_value(pv1),
    .peak_channel(pc1), .result_valid(rv1), .busy(busy1), .overrun(ovr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en0) rdat0 <= mem0[addr0];
    if (en1) rdat1 <= mem1[addr1];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) chk("rv0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("sum0", sum0, e.sum);   chk("wsum0", wsum0, e.wsum);
        chk("peak0", pv0, e.pv);    chk("peakch0", pc0, e.pc);
      end
    end
    if (rv1) begin
      if (q1.size() == 0) chk("rv1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("sum1", sum1, e.sum);   chk("wsum1", wsum1, e.wsum);
        chk("peak1", pv1, e.pv);    chk("peakch1", pc1, e.pc);
      end
    end
  end

  // kind: 0 ramp, 1 single spike, 2 equal spikes, 3 threshold pattern, 4 zeros
  task automatic fill(input bit which, input int kind);
    logic [31:0] v;
    for (int a = 0; a < 512; a++) begin
      if (a == 0 || a > 320) v = 32'hF000_0000 + 32'(a);
      else begin
        case (kind)
          0: v = 32'(a);
          1: v = (a - 1 == 100) ? 32'd5000 : 32'd0;
          2: v = (a - 1 == 10 || a - 1 == 200) ? 32'd7 : 32'd0;
          3: v = (a - 1 == 5) ? 32'd25 : 32'd8;
          default: v = 32'd0;
        endcase
      end
      if (which) mem1[a] = v; else mem0[a] = v;
    end
  endtask

  task automatic model(input bit which, output exp_t e);
    logic [31:0] d, c, th;
    e = '0;
    th = which ? 32'd10 : 32'd0;
    for (int ch = 0; ch < 320; ch++) begin
      d = which ? mem1[ch + 1] : mem0[ch + 1];
      c = (d > th) ? d - th : 32'd0;
      e.sum  = e.sum + 41'(c);
      e.wsum = e.wsum + 50'(c) * 50'(ch);
      if (c > e.pv) begin
        e.pv = c;
        e.pc = 9'(ch);
      end
    end
  endtask

  task automatic run_frame(input bit which, input int extra_at, input int rst_at);
    exp_t e;
    int n, nexp, lat;
    bit sweep_ok, aborted;
    sel = which;
    model(which, e);
    if (rst_at < 0) begin
      if (which) q1.push_back(e); else q0.push_back(e);
    end
    @(negedge clk); start_drv = 1'b1;
    @(posedge clk); #1; start_drv = 1'b0;
    chk("busy_after_start", v_busy, 1);
    n = 0; nexp = 0; lat = -1; sweep_ok = 1'b1; aborted = 1'b0;
    while (n < 1000) begin
      @(posedge clk); n++; #1;
      if (n == extra_at) start_drv = 1'b1;
      else if (n == extra_at + 1) start_drv = 1'b0;
      if (v_en) begin
        if (v_addr != 9'(nexp + 1)) sweep_ok = 1'b0;
        nexp++;
      end
      if (n == rst_at) begin
        chk("addr_at_rst", v_addr, 151);
        rst = 1'b1; #1;
        chk("rst_rd_enable", v_en, 0);    chk("rst_rd_address", v_addr, 0);
        chk("rst_sum", v_sum, 0);         chk("rst_wsum", v_wsum, 0);
        chk("rst_peak", v_pv, 0);         chk("rst_peakch", v_pc, 0);
        chk("rst_busy", v_busy, 0);       chk("rst_overrun", v_ovr, 0);
        @(negedge clk); rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (v_rv) begin
        lat = n;
        break;
      end
    end
    start_drv = 1'b0;
    if (!aborted) begin
      chk("latency", lat, 327);
      chk("busy_at_valid", v_busy, 0);
      chk("sweep_count", nexp, 320);
      chk("sweep_order", sweep_ok, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_sum", v_sum, e.sum);
      chk("hold_peakch", v_pc, e.pc);
    end
  endtask

  initial begin
    int busy_seen;
    rst = 1'b1; start_drv = 1'b0; sel = 1'b0;
    fill(0, 4); fill(1, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", sum0, 0);      chk("reset_wsum", wsum0, 0);
    chk("reset_peak", pv0, 0);      chk("reset_peakch", pc0, 0);
    chk("reset_rv", rv0, 0);        chk("reset_busy", busy0, 0);
    chk("reset_overrun", ovr0, 0);  chk("reset_rd_enable", en0, 0);
    chk("reset_rd_address", addr0, 0);
    @(negedge clk); rst = 1'b0;

    fill(0, 0); run_frame(0, -10, -1);
    chk("ramp_sum", sum0, 51360);   chk("ramp_wsum", wsum0, 10922560);
    chk("ramp_peak", pv0, 320);     chk("ramp_peakch", pc0, 319);

    fill(0, 1); run_frame(0, -10, -1);
    chk("spike_wsum", wsum0, 500000);  chk("spike_peakch", pc0, 100);

    fill(0, 2); run_frame(0, -10, -1);
    chk("tie_peakch", pc0, 10);     chk("tie_wsum", wsum0, 1470);

    fill(0, 4); run_frame(0, -10, -1);
    chk("zero_peakch", pc0, 0);     chk("zero_sum", sum0, 0);

    // Threshold instance, with a start that coincides with DONE.
    fill(1, 3); run_frame(1, 326, -1);
    chk("th_sum", sum1, 15);        chk("th_wsum", wsum1, 75);
    chk("th_peakch", pc1, 5);       chk("done_start_overrun", ovr1, 1);
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy1) busy_seen++;
    end
    chk("done_start_ignored", busy_seen, 0);

    sel = 1'b0;
    chk("overrun_before", ovr0, 0);
    fill(0, 0); run_frame(0, 54, -1);
    chk("overrun_set", ovr0, 1);
    fill(0, 1); run_frame(0, -10, -1);
    chk("overrun_sticky", ovr0, 1);

    fill(0, 0); run_frame(0, -10, 154);
    repeat (400) @(posedge clk);
    #1;
    chk("no_result_after_rst", q0.size(), 0);
    run_frame(0, -10, -1);
    chk("post_rst_sum", sum0, 51360);  chk("post_rst_peakch", pc0, 319);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
